// File: rtl/mux_5_bit.sv
// mux_5_bit: registered two-input mux with capture enable and a sticky valid flag
module mux_5_bit #(
   parameter int               WIDTH       = 5,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   input  logic             select,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   // capture the selected input when enabled (anything but a clean 1 picks in_0), else hold
   always_comb begin
      out_d   = en ? ((select === 1'b1) ? in_1 : in_0) : out_q;
      valid_d = valid_q | en;
   end
   // state register; reset wins over any pending capture
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= RESET_VALUE;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end
   assign out       = out_q;
   assign out_valid = valid_q;
endmodule

// File: tb/tb_mux_5_bit.sv
// tb_mux_5_bit: scoreboard bench for 5-bit and 32-bit mux_5_bit instances
module tb_mux_5_bit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  in_0 = '0, in_1 = '0;
   logic [31:0] w_0 = '0, w_1 = '0;
   logic        select = 1'b0, en = 1'b0;
   logic [4:0]  out;
   logic [31:0] w_out;
   logic        out_valid, w_valid;
   int          checks = 0, errors = 0;
   typedef struct packed {
      logic [4:0]  o5;
      logic        v5;
      logic [31:0] o32;
      logic        v32;
   } exp_t;
   exp_t        q[$];
   exp_t        e;
   logic [4:0]  m5 = '0;
   logic [31:0] m32 = '0;
   logic        mv = 1'b0;

   mux_5_bit dut5 (
      .clk(clk), .rst(rst), .in_0(in_0), .in_1(in_1), .select(select), .en(en),
      .out(out), .out_valid(out_valid)
   );
   mux_5_bit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_0(w_0), .in_1(w_1), .select(select), .en(en),
      .out(w_out), .out_valid(w_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // one transaction: drive at negedge, update reference state, queue the expectation
   task automatic step(input logic r, input logic [4:0] a0, input logic [4:0] a1,
                       input logic s, input logic e_in, input logic [31:0] b0, input logic [31:0] b1);
      @(negedge clk);
      rst = r; in_0 = a0; in_1 = a1; select = s; en = e_in; w_0 = b0; w_1 = b1;
      if (r) begin
         m5 = '0; m32 = '0; mv = 1'b0;
      end else if (e_in) begin
         m5  = (s === 1'b1) ? a1 : a0;
         m32 = (s === 1'b1) ? b1 : b0;
         mv  = 1'b1;
      end
      q.push_back('{o5: m5, v5: mv, o32: m32, v32: mv});
      @(posedge clk);
      #2;
      in_0 = 5'($urandom); in_1 = 5'($urandom); w_0 = $urandom; w_1 = $urandom;
      select = 1'($urandom);
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("out5", 32'(out), 32'(e.o5));
         chk("valid5", 32'(out_valid), 32'(e.v5));
         chk("out32", w_out, e.o32);
         chk("valid32", 32'(w_valid), 32'(e.v32));
      end
   end

   initial begin
      step(1, 5'b10101, 5'b11111, 0, 1, $urandom, $urandom);
      step(1, 5'b10101, 5'b11111, 1, 1, $urandom, $urandom);
      step(0, 5'd0, 5'b11111, 0, 1, $urandom, $urandom);
      step(0, 5'd0, 5'b11111, 1, 1, $urandom, 32'hAAAAAAAA);
      step(0, 5'd0, 5'b01010, 1, 1, $urandom, $urandom);
      step(0, 5'b10101, 5'b01010, 0, 1, $urandom, $urandom);
      for (int i = 0; i < 3; i++)
         step(0, 5'($urandom), 5'($urandom), 1'(i), 0, $urandom, $urandom);
      step(0, 5'b00111, 5'b11000, 1, 1, $urandom, $urandom);
      step(1, 5'b01100, 5'b10011, 0, 1, $urandom, $urandom);
      step(0, 5'b01100, 5'b10011, 0, 1, $urandom, $urandom);
      step(0, 5'b01110, 5'b01110, 1, 1, 32'h12345678, 32'h12345678);
      step(0, 5'b01110, 5'b01110, 0, 1, 32'h12345678, 32'h12345678);
      step(0, 5'b11001, 5'b00110, 1'bx, 1, $urandom, $urandom);
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 19) == 0), 5'($urandom), 5'($urandom), 1'($urandom),
              1'($urandom), $urandom, $urandom);
      step(0, 5'($urandom), 5'($urandom), 1'($urandom), 0, $urandom, $urandom);
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux_5_bit.md
MUX_5_BIT -- requirements
Module: mux_5_bit

Interface
REQ-001 Parameter WIDTH, default 5, data width of in_0, in_1 and out (register-address width); the block SHALL support any WIDTH >= 1.
REQ-002 Parameter RESET_VALUE, default 0 (WIDTH bits), value loaded into out on reset.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 in_0  input  WIDTH  data selected when select = 0.
REQ-006 in_1  input  WIDTH  data selected when select = 1.
REQ-007 select  input  1  choice between in_0 (0) and in_1 (1).
REQ-008 en  input  1  capture enable; when 1, the selected input is registered.
REQ-009 out  output  WIDTH  registered mux result.
REQ-010 out_valid  output  1  1 when out holds a value captured since the last reset.

Function
REQ-011 On each rising clk edge with rst = 0 and en = 1, out SHALL load in_0 if select = 0, else in_1.
REQ-012 Latency SHALL be exactly one clock: out reflects the inputs sampled at the preceding edge; out SHALL NOT have a combinational path from any input.
REQ-013 With rst = 0 and en = 0, out and out_valid SHALL hold their values.
REQ-014 out_valid SHALL become 1 on the first edge with rst = 0 and en = 1 after reset, and SHALL stay 1 until the next reset.
REQ-015 No arithmetic is performed; bits SHALL pass through unmodified, bit i of out coming from bit i of the selected input.
REQ-016 Input changes between clock edges SHALL have no effect on out; only values present at the edge matter.
REQ-017 Simultaneous changes of select and data before the same edge SHALL produce the newly selected new data at that edge.
REQ-018 in_0 = in_1 SHALL yield that value regardless of select.
REQ-019 Any select value other than a clean 1 SHALL be treated as 0 (in_0 selected).

Reset
REQ-020 When rst = 1 at a rising edge, out SHALL load RESET_VALUE and out_valid SHALL load 0, regardless of en, select and data.
REQ-021 rst SHALL have priority over en; reset asserted mid-operation SHALL take effect at the next edge and discard the pending capture.
REQ-022 On the first edge after rst deasserts, normal capture per REQ-011 SHALL resume with no extra dead cycle.
REQ-023 Before the first reset edge, out and out_valid are unspecified; the bench SHALL apply reset first.

Verification
REQ-024 rst = 1 for 2 cycles with in_0 = 5'b10101, in_1 = 5'b11111, en = 1 -> out = 0, out_valid = 0 during reset.
REQ-025 in_0 = 0, in_1 = 5'b11111, select = 0, en = 1 -> one edge later out = 0, out_valid = 1; then select = 1 -> next edge out = 31.
REQ-026 select = 1, in_1 changed to 5'b01010 -> next edge out = 10; then in_0 = 5'b10101 and select = 0 applied together -> next edge out = 21.
REQ-027 en = 0 while toggling select and both inputs for 3 cycles -> out and out_valid unchanged; en = 1 again -> the current selection appears one edge later.
REQ-028 rst = 1 for one cycle during active capture with en = 1 -> out = 0 and out_valid = 0 at that edge, capture resumes on the next edge.
REQ-029 WIDTH = 32 instance: in_1 = 32'hAAAAAAAA, select = 1, en = 1 -> out = 32'hAAAAAAAA after one edge.
